call_stack_ctrl: RTL
====================

# call_stack_ctrl

Call/return sequencer that drives the register file's context-stack interface (`rf_stack_push`, `rf_stack_pop`, `rf_stack_pointer`) on behalf of the control unit. On CALL it pushes the working-register context and stores the return PC. On RET it restores the context and hands back the return PC. It owns the stack pointer, enforces depth limits and serialises requests through a small FSM.

## Interface
Parameters:
- `PC_WIDTH`, 5: width of PC and of `rf_stack_pointer`.
- `MAX_DEPTH`, 8: maximum nested frames; must be ≤ 2^PC_WIDTH − 1.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_call_req`  in  1: CALL request, level, held until `cs_ack`.
- `cs_call_pc`  in  PC_WIDTH: return address to save, valid with `cs_call_req`.
- `cs_ret_req`  in  1: RET request, level, held until `cs_ack`.
- `cs_ack`  out  1: one-cycle completion pulse.
- `cs_ret_pc`  out  PC_WIDTH: restored return address, valid in `cs_ack` cycle of a RET.
- `cs_busy`  out  1: FSM not IDLE.
- `cs_depth`  out  PC_WIDTH: current frame count (sp).
- `rf_stack_push`  out  1: to register file/stack, write context at pointer.
- `rf_stack_pop`  out  1: to register file, load context from pointer.
- `rf_stack_pointer`  out  PC_WIDTH: frame address.
- `cs_overflow`, `cs_underflow`  out  1 each: sticky error flags (see Configuration).

## Operation
- Frames live at addresses 1..MAX_DEPTH. sp = frame count. Address 0 is never written, which matches the register file's pop guard (pointer > 0).
- FSM states: IDLE, PUSH, RD, POP.
- IDLE: if `cs_call_req` then PUSH; else if `cs_ret_req` then RD. CALL wins when both are high; RET stays pending and is taken on the next IDLE sample.
- PUSH, normal (sp < MAX_DEPTH):
  - Drive `rf_stack_pointer` = sp+1 and `rf_stack_push` = 1.
  - Write `cs_call_pc` into LIFO[sp+1].
  - `cs_ack` = 1; sp ← sp+1 at the end of the cycle; return to IDLE.
- PUSH, overflow (sp == MAX_DEPTH):
  - `rf_stack_push` held 0, no LIFO write, sp unchanged.
  - `cs_ack` = 1; overflow flag set.
- RD: `rf_stack_pointer` = sp, so the stack has its synchronous read latency. `cs_ret_pc` ← LIFO[sp], or 0 if sp == 0. Go to POP.
- POP, normal (sp > 0):
  - `rf_stack_pop` = 1, `rf_stack_pointer` = sp.
  - `cs_ack` = 1; sp ← sp−1 at the end of the cycle; return to IDLE.
- POP, underflow (sp == 0):
  - `rf_stack_pop` = 0, sp stays 0, `cs_ret_pc` = 0.
  - `cs_ack` = 1; underflow flag set.
- IDLE pointer: `rf_stack_pointer` = sp.
- `rf_stack_push` and `rf_stack_pop` are decoded from state only and are never high together.
- sp arithmetic is unsigned, PC_WIDTH bits. It never wraps because the overflow/underflow checks guard it.

## Timing
- Reset values: state IDLE, sp 0, `cs_ret_pc` 0, flags 0, all strobes and `cs_ack` 0, `rf_stack_pointer` 0.
- LIFO contents are not reset.
- CALL latency: request sampled at edge N; PUSH and `cs_ack` in cycle N+1; new sp visible in cycle N+2.
- RET latency: request sampled at edge N; RD in cycle N+1; POP, `cs_ack` and `cs_ret_pc` in cycle N+2.
- Handshake: the requester drops its request on the edge that samples `cs_ack`. The following IDLE cycle therefore sees a new request only if one was raised intentionally. Back-to-back throughput is one CALL per 2 cycles, one RET per 3 cycles.
- Requests during a non-IDLE state are ignored, not queued.
- Reset mid-operation: async return to IDLE, sp = 0, strobes drop immediately. Any in-flight operation is dropped with no `cs_ack`.

## Configuration
- `CALL_STACK_ERR_EN` defined:
  - `cs_overflow` / `cs_underflow` are registered sticky flags, set on an illegal CALL/RET.
  - Cleared only by `rst_n`.
- Not defined:
  - Both flags are tied to 0 and no flag registers exist.
  - Illegal requests are still acked with no push/pop and no sp change.

## Structure
- `call_stack_pkg`: FSM state enum (`CS_IDLE`, `CS_PUSH`, `CS_RD`, `CS_POP`) and a sp/depth type derived from PC_WIDTH.
- Sub-module `ret_addr_lifo`: MAX_DEPTH×PC_WIDTH return-address array with one write port (address, data, we) and a registered read.
- All sequencing stays in `call_stack_ctrl`.

## Test plan
- Reset, then CALL with pc = 5'h07:
  - PUSH cycle shows push = 1, pointer = 1, ack = 1.
  - Then `cs_depth` = 1, pointer = 1.
- CALL 5'h07 then RET:
  - RD then POP with pop = 1, pointer = 1, `cs_ret_pc` = 5'h07, ack = 1.
  - Then depth = 0.
- Three nested CALLs (5'h03, 5'h0A, 5'h11), then three RETs:
  - `cs_ret_pc` = 5'h11, 5'h0A, 5'h03 in order.
  - Pointers 3, 2, 1.
- CALL and RET high together at depth 0:
  - CALL is served first (depth 1).
  - RET is served next and returns the CALL pc; final depth 0.
- Nine CALLs with MAX_DEPTH = 8, then RET at depth 0 after draining:
  - Ninth CALL acked with push = 0, depth stays 8; underflow RET gives pop = 0, `cs_ret_pc` = 0.
  - With `CALL_STACK_ERR_EN` defined, `cs_overflow` and `cs_underflow` are 1; without it, both are 0.
- `rst_n` low during RD at depth 2:
  - Strobes 0 immediately, no ack, depth 0.
  - A subsequent RET is treated as underflow.

Source files
------------

// File: rtl/call_stack_ctrl_pkg.sv
// call_stack_pkg: shared types for the call/return sequencer.
package call_stack_pkg;

  localparam int unsigned CS_PC_WIDTH  = 5;
  localparam int unsigned CS_MAX_DEPTH = 8;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_PUSH,
    CS_RD,
    CS_POP
  } cs_state_t;

  // Stack pointer / frame count, same width as a PC.
  typedef logic [CS_PC_WIDTH-1:0] cs_sp_t;

endpackage

// File: rtl/call_stack_ctrl_if.sv
// call_stack_ctrl_if: control-unit side request/acknowledge bundle.
interface call_stack_ctrl_if
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH = CS_PC_WIDTH
);
  logic                cs_call_req;
  logic [PC_WIDTH-1:0] cs_call_pc;
  logic                cs_ret_req;
  logic                cs_ack;
  logic [PC_WIDTH-1:0] cs_ret_pc;
  logic                cs_busy;
  logic [PC_WIDTH-1:0] cs_depth;
  logic                cs_overflow;
  logic                cs_underflow;

  modport master (
    output cs_call_req, cs_call_pc, cs_ret_req,
    input  cs_ack, cs_ret_pc, cs_busy, cs_depth, cs_overflow, cs_underflow
  );

  modport slave (
    input  cs_call_req, cs_call_pc, cs_ret_req,
    output cs_ack, cs_ret_pc, cs_busy, cs_depth, cs_overflow, cs_underflow
  );
endinterface

// File: rtl/call_stack_ctrl_ret_addr_lifo.sv
// ret_addr_lifo: return-address storage, frames at 1..MAX_DEPTH,
// one write port and a registered read. Address 0 / out-of-range read as 0.
module ret_addr_lifo #(
  parameter int unsigned PC_WIDTH  = 5,
  parameter int unsigned MAX_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [PC_WIDTH-1:0] i_waddr,
  input  logic [PC_WIDTH-1:0] i_wdata,
  input  logic                i_re,
  input  logic [PC_WIDTH-1:0] i_raddr,
  output logic [PC_WIDTH-1:0] o_rdata
);
  localparam int unsigned AW = $clog2(MAX_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] MAX_ADDR = PC_WIDTH'(MAX_DEPTH);

  logic [PC_WIDTH-1:0] r_mem [MAX_DEPTH+1];
  logic [PC_WIDTH-1:0] r_rdata;
  logic                w_wr_ok;
  logic                w_rd_ok;

  assign w_wr_ok = (i_waddr != '0) && (i_waddr <= MAX_ADDR);
  assign w_rd_ok = (i_raddr != '0) && (i_raddr <= MAX_ADDR);

  // Array write; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) r_mem[i_waddr[AW-1:0]] <= i_wdata;
  end

  // Registered read, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= w_rd_ok ? r_mem[i_raddr[AW-1:0]] : '0;
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: CALL/RET sequencer driving the register-file context stack.
// Optional sticky error flags: define CALL_STACK_ERR_EN.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = CS_PC_WIDTH,
  parameter int unsigned MAX_DEPTH = CS_MAX_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  call_stack_ctrl_if.slave    cs,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer
);
  localparam logic [PC_WIDTH-1:0] MAX_SP = PC_WIDTH'(MAX_DEPTH);

  cs_state_t           r_state, w_state_next;
  logic [PC_WIDTH-1:0] r_sp, w_sp_next;
  logic [PC_WIDTH-1:0] w_ptr;
  logic                w_push, w_pop, w_ack, w_we, w_re;
  logic [PC_WIDTH-1:0] w_rdata;

  // State and stack-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CS_IDLE;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
    end
  end

  // Next-state, strobes and pointer.
  always_comb begin
    w_state_next = r_state;
    w_sp_next    = r_sp;
    w_ptr        = r_sp;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ack        = 1'b0;
    w_we         = 1'b0;
    w_re         = 1'b0;
    unique case (r_state)
      CS_IDLE: begin
        if (cs.cs_call_req)     w_state_next = CS_PUSH;
        else if (cs.cs_ret_req) w_state_next = CS_RD;
      end
      CS_PUSH: begin
        w_ack        = 1'b1;
        w_state_next = CS_IDLE;
        if (r_sp < MAX_SP) begin
          w_ptr     = r_sp + 1'b1;
          w_push    = 1'b1;
          w_we      = 1'b1;
          w_sp_next = r_sp + 1'b1;
        end
      end
      CS_RD: begin
        w_re         = 1'b1;
        w_state_next = CS_POP;
      end
      CS_POP: begin
        w_ack        = 1'b1;
        w_state_next = CS_IDLE;
        if (r_sp != '0) begin
          w_pop     = 1'b1;
          w_sp_next = r_sp - 1'b1;
        end
      end
      default: w_state_next = CS_IDLE;
    endcase
  end

  ret_addr_lifo #(
    .PC_WIDTH (PC_WIDTH),
    .MAX_DEPTH(MAX_DEPTH)
  ) u_lifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(w_ptr),
    .i_wdata(cs.cs_call_pc),
    .i_re   (w_re),
    .i_raddr(r_sp),
    .o_rdata(w_rdata)
  );

`ifdef CALL_STACK_ERR_EN
  logic r_ovf, r_unf;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (r_state == CS_PUSH && r_sp == MAX_SP) r_ovf <= 1'b1;
      if (r_state == CS_POP  && r_sp == '0)     r_unf <= 1'b1;
    end
  end

  assign cs.cs_overflow  = r_ovf;
  assign cs.cs_underflow = r_unf;
`else
  assign cs.cs_overflow  = 1'b0;
  assign cs.cs_underflow = 1'b0;
`endif

  assign cs.cs_ack         = w_ack;
  assign cs.cs_ret_pc      = w_rdata;
  assign cs.cs_busy        = (r_state != CS_IDLE);
  assign cs.cs_depth       = r_sp;
  assign rf_stack_push     = w_push;
  assign rf_stack_pop      = w_pop;
  assign rf_stack_pointer  = w_ptr;
endmodule
